pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. Drives en/bubbleSel of IFID, IDEX, EXME, MEWB and the PC

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stalls, flushes,
// memory wait, perf counters and sticky memory timeout.
module pipe_hazard_ctrl #(
  parameter int FORWARDING  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsID,
  input  logic [4:0]       rtID,
  input  logic             useRtID,
  input  logic [4:0]       rdEX,
  input  logic             wrEX,
  input  logic             ldEX,
  input  logic [4:0]       rdME,
  input  logic             wrME,
  input  logic [4:0]       rdWB,
  input  logic             wrWB,
  input  logic             brTakenME,
  input  logic             memReqME,
  input  logic             memReady,
  output logic             pcEn,
  output logic             ifidEn,
  output logic             ifidBubble,
  output logic             idexEn,
  output logic             idexBubble,
  output logic             exmeEn,
  output logic             exmeBubble,
  output logic             mewbEn,
  output logic             mewbBubble,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic             memErr
);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH,
    MEMWAIT
  } state_t;

  localparam logic [7:0] TO8 = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] waitCnt;
  logic [7:0] nextWait;

  logic exHit, meHit, wbHit;
  logic hazard, memWait, inShadow;
  logic mwAct, flAct, stAct;

  function automatic logic srcHit(
    input logic [4:0] rd,
    input logic       wr,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       useRt
  );
    return wr && (rd != 5'd0) &&
           ((rs == rd) || (useRt && (rt == rd)));
  endfunction

  assign exHit = srcHit(rdEX, wrEX, rsID, rtID, useRtID);
  assign meHit = srcHit(rdME, wrME, rsID, rtID, useRtID);
  assign wbHit = srcHit(rdWB, wrWB, rsID, rtID, useRtID);

  assign hazard = (FORWARDING != 0) ? (ldEX & exHit)
                                    : (exHit | meHit | wbHit);

  assign memWait  = memReqME & ~memReady;
  assign inShadow = (state == FLUSH);

  assign mwAct = ~reset & memWait;
  assign flAct = ~reset & ~memWait & ~inShadow & brTakenME;
  assign stAct = ~reset & ~memWait & ~inShadow & ~brTakenME & hazard;

  assign nextWait = (waitCnt == TO8) ? waitCnt : waitCnt + 8'd1;

  // Stage enables and bubble selects for this cycle's action
  always_comb begin
    pcEn       = 1'b1;
    ifidEn     = 1'b1;
    ifidBubble = 1'b0;
    idexEn     = 1'b1;
    idexBubble = 1'b0;
    exmeEn     = 1'b1;
    exmeBubble = 1'b0;
    mewbEn     = 1'b1;
    mewbBubble = 1'b0;
    unique case (1'b1)
      reset: begin
        pcEn       = 1'b0;
        ifidBubble = 1'b1;
        idexBubble = 1'b1;
        exmeBubble = 1'b1;
        mewbBubble = 1'b1;
      end
      mwAct: begin
        pcEn       = 1'b0;
        ifidEn     = 1'b0;
        idexEn     = 1'b0;
        exmeEn     = 1'b0;
        mewbBubble = 1'b1;
      end
      flAct: begin
        ifidBubble = 1'b1;
        idexBubble = 1'b1;
        exmeBubble = 1'b1;
      end
      stAct: begin
        pcEn       = 1'b0;
        ifidEn     = 1'b0;
        idexBubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state, wait timer, counters and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      waitCnt    <= 8'd0;
      stallCount <= '0;
      flushCount <= '0;
      memErr     <= 1'b0;
    end else begin
      unique case (1'b1)
        mwAct:   state <= MEMWAIT;
        flAct:   state <= FLUSH;
        stAct:   state <= STALL;
        default: state <= RUN;
      endcase
      if (mwAct) begin
        waitCnt <= nextWait;
        if (nextWait == TO8)
          memErr <= 1'b1;
      end else begin
        waitCnt <= 8'd0;
      end
      if ((mwAct || stAct) && (stallCount != '1))
        stallCount <= stallCount + CNT_W'(1);
      if (flAct && (flushCount != '1))
        flushCount <= flushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations on shared
// stimulus, checked against a cycle-level action model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsID, rtID, rdEX, rdME, rdWB;
  logic useRtID, wrEX, ldEX, wrME, wrWB;
  logic brTakenME, memReqME, memReady;

  logic [1:0] pcEn, ifidEn, ifidBubble, idexEn, idexBubble;
  logic [1:0] exmeEn, exmeBubble, mewbEn, mewbBubble, memErr;
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  int nChecks = 0;
  int nFail   = 0;

  int fwdP[2] = '{1, 0};
  int toP[2]  = '{255, 3};
  int maxP[2] = '{65535, 15};

  bit mShadow[2];
  bit mErr[2];
  int mSc[2], mFc[2], mWc[2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FORWARDING(1), .MEM_TIMEOUT(255), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .rsID(rsID), .rtID(rtID),
    .useRtID(useRtID), .rdEX(rdEX), .wrEX(wrEX), .ldEX(ldEX),
    .rdME(rdME), .wrME(wrME), .rdWB(rdWB), .wrWB(wrWB),
    .brTakenME(brTakenME), .memReqME(memReqME), .memReady(memReady),
    .pcEn(pcEn[0]), .ifidEn(ifidEn[0]), .ifidBubble(ifidBubble[0]),
    .idexEn(idexEn[0]), .idexBubble(idexBubble[0]),
    .exmeEn(exmeEn[0]), .exmeBubble(exmeBubble[0]),
    .mewbEn(mewbEn[0]), .mewbBubble(mewbBubble[0]),
    .stallCount(sc0), .flushCount(fc0), .memErr(memErr[0])
  );

  pipe_hazard_ctrl #(.FORWARDING(0), .MEM_TIMEOUT(3), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .rsID(rsID), .rtID(rtID),
    .useRtID(useRtID), .rdEX(rdEX), .wrEX(wrEX), .ldEX(ldEX),
    .rdME(rdME), .wrME(wrME), .rdWB(rdWB), .wrWB(wrWB),
    .brTakenME(brTakenME), .memReqME(memReqME), .memReady(memReady),
    .pcEn(pcEn[1]), .ifidEn(ifidEn[1]), .ifidBubble(ifidBubble[1]),
    .idexEn(idexEn[1]), .idexBubble(idexBubble[1]),
    .exmeEn(exmeEn[1]), .exmeBubble(exmeBubble[1]),
    .mewbEn(mewbEn[1]), .mewbBubble(mewbBubble[1]),
    .stallCount(sc1), .flushCount(fc1), .memErr(memErr[1])
  );

  task automatic chk(string tag, longint got, longint exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Bubble bits only matter where the matching enable is set
  function automatic logic [8:0] eff(logic [8:0] v);
    logic [8:0] r;
    r = v;
    r[6] = v[6] & v[7];
    r[4] = v[4] & v[5];
    r[2] = v[2] & v[3];
    r[0] = v[0] & v[1];
    return r;
  endfunction

  function automatic logic [8:0] gotVec(int i);
    return {pcEn[i], ifidEn[i], ifidBubble[i], idexEn[i],
            idexBubble[i], exmeEn[i], exmeBubble[i],
            mewbEn[i], mewbBubble[i]};
  endfunction

  function automatic int gotSc(int i);
    return (i == 0) ? int'(sc0) : int'(sc1);
  endfunction

  function automatic int gotFc(int i);
    return (i == 0) ? int'(fc0) : int'(fc1);
  endfunction

  function automatic bit hz(int i);
    logic [4:0] rd[3];
    bit wr[3];
    int n;
    rd = '{rdEX, rdME, rdWB};
    wr = '{wrEX, wrME, wrWB};
    n = (fwdP[i] != 0) ? 1 : 3;
    for (int k = 0; k < n; k++) begin
      if (wr[k] && rd[k] != 0 &&
          (rsID == rd[k] || (useRtID && rtID == rd[k])) &&
          (fwdP[i] == 0 || ldEX))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // 0 reset, 1 memwait, 2 flush, 3 stall, 4 run
  function automatic int action(int i);
    if (reset) return 0;
    if (memReqME && !memReady) return 1;
    if (!mShadow[i] && brTakenME) return 2;
    if (!mShadow[i] && hz(i)) return 3;
    return 4;
  endfunction

  function automatic logic [8:0] expVec(int act);
    case (act)
      0:       return 9'b0_11_11_11_11;
      1:       return 9'b0_00_00_00_11;
      2:       return 9'b1_11_11_11_10;
      3:       return 9'b0_00_11_10_10;
      default: return 9'b1_10_10_10_10;
    endcase
  endfunction

  function automatic void update(int i, int act);
    if (act == 0) begin
      mShadow[i] = 0;
      mErr[i] = 0;
      mSc[i] = 0;
      mFc[i] = 0;
      mWc[i] = 0;
      return;
    end
    if (act == 1) begin
      if (mWc[i] < toP[i]) mWc[i]++;
      if (mWc[i] >= toP[i]) mErr[i] = 1;
    end else begin
      mWc[i] = 0;
    end
    if ((act == 1 || act == 3) && mSc[i] < maxP[i]) mSc[i]++;
    if (act == 2 && mFc[i] < maxP[i]) mFc[i]++;
    mShadow[i] = (act == 2);
  endfunction

  task automatic cycle();
    int act[2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      act[i] = action(i);
      chk($sformatf("out%0d", i), eff(gotVec(i)), eff(expVec(act[i])));
      chk($sformatf("stallCnt%0d", i), gotSc(i), mSc[i]);
      chk($sformatf("flushCnt%0d", i), gotFc(i), mFc[i]);
      chk($sformatf("memErr%0d", i), memErr[i], mErr[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) update(i, act[i]);
    #1;
  endtask

  task automatic clr();
    reset = 0;
    rsID = 0; rtID = 0; useRtID = 0;
    rdEX = 0; wrEX = 0; ldEX = 0;
    rdME = 0; wrME = 0; rdWB = 0; wrWB = 0;
    brTakenME = 0; memReqME = 0; memReady = 0;
  endtask

  task automatic doReset();
    clr();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    clr();
    reset = 1;
    @(posedge clk);
    #1;
    doReset();

    // load-use with forwarding: one stall cycle
    rdEX = 5; wrEX = 1; ldEX = 1; rsID = 5;
    cycle();
    rdEX = 0; wrEX = 0; ldEX = 0; rdME = 5; wrME = 1;
    cycle();
    chk("s1_stallCount", sc0, 1);

    // no forwarding: stall until the writer leaves WB
    doReset();
    rdME = 3; wrME = 1; rtID = 3; useRtID = 1;
    cycle();
    rdME = 0; wrME = 0; rdWB = 3; wrWB = 1;
    cycle();
    clr(); rtID = 3; useRtID = 1;
    cycle();
    chk("s2_stallCount", sc1, 2);
    rdME = 3; wrME = 1; useRtID = 0;
    cycle();
    chk("s2_noRt", sc1, 2);

    // taken branch, held signal ignored in the shadow cycle
    doReset();
    brTakenME = 1;
    cycle();
    cycle();
    clr();
    cycle();
    chk("s3_flushCount", fc0, 1);

    // memory wait of four cycles, timeout on the short config
    doReset();
    memReqME = 1;
    repeat (4) cycle();
    memReady = 1;
    cycle();
    chk("s4_stallCount", sc0, 4);
    chk("s5_memErrSet", memErr[1], 1);
    chk("s5_memErrLong", memErr[0], 0);
    clr();
    repeat (2) cycle();
    chk("s5_memErrSticky", memErr[1], 1);

    // reset during memwait, then rd=0 never stalls
    memReqME = 1;
    cycle();
    doReset();
    chk("s6_stallCount", sc0, 0);
    chk("s6_memErrClr", memErr[1], 0);
    rdEX = 0; wrEX = 1; ldEX = 1; rsID = 0;
    cycle();
    chk("s6_rd0", sc0, 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      rsID      = 5'($urandom_range(0, 3));
      rtID      = 5'($urandom_range(0, 3));
      useRtID   = 1'($urandom_range(0, 1));
      rdEX      = 5'($urandom_range(0, 3));
      wrEX      = 1'($urandom_range(0, 1));
      ldEX      = 1'($urandom_range(0, 1));
      rdME      = 5'($urandom_range(0, 3));
      wrME      = 1'($urandom_range(0, 1));
      rdWB      = 5'($urandom_range(0, 3));
      wrWB      = 1'($urandom_range(0, 1));
      brTakenME = ($urandom_range(0, 6) == 0);
      memReqME  = ($urandom_range(0, 2) == 0);
      memReady  = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
